// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels.
// Imported by both the transmit framer and the receive side.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } tx_state_t;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side send handshake of the UART transmit framer.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 send;
   logic [DATA_BITS-1:0] din;
   logic                 busy;
   logic                 done;

   modport master (output send, output din, input busy, input done);
   modport slave  (input send, input din, output busy, output done);

endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start / LSB-first data / optional parity / stop, paced by tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int BIT_CNT_W = $clog2(DATA_BITS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   output logic          tx,
   uart_tx_frame_if.slave host
);

   localparam logic [BIT_CNT_W-1:0] LAST_IDX = BIT_CNT_W'(DATA_BITS - 1);

   tx_state_t            state_r;
   tx_state_t            state_s;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_s;
   logic [BIT_CNT_W-1:0] idx_r;
   logic [BIT_CNT_W-1:0] idx_s;
   logic                 busy_r;
   logic                 done_r;
   logic                 done_s;
   logic                 tx_r;
   logic                 tx_s;

`ifdef UART_TX_PARITY_EN
   logic                 parity_r;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
      return ^word;
   endfunction

   // Parity is taken from the word as accepted, since the shift register drains it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_r <= 1'b0;
      end else if ((state_r == IDLE) && host.send) begin
         parity_r <= even_parity(host.din);
      end else begin
         parity_r <= parity_r;
      end
   end
`endif

   // Next-state, shift register and bit-index update
   always_comb begin
      state_s = state_r;
      shift_s = shift_r;
      idx_s   = idx_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (host.send) begin
               state_s = SYNC;
               shift_s = host.din;
            end else begin
               state_s = IDLE;
            end
         end
         SYNC: begin
            if (tick) begin
               state_s = START;
            end else begin
               state_s = SYNC;
            end
         end
         START: begin
            if (tick) begin
               state_s = DATA;
               idx_s   = {BIT_CNT_W{1'b0}};
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (tick) begin
               shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
               if (idx_r == LAST_IDX) begin
                  idx_s = {BIT_CNT_W{1'b0}};
`ifdef UART_TX_PARITY_EN
                  state_s = PARITY;
`else
                  state_s = STOP;
`endif
               end else begin
                  idx_s = idx_r + BIT_CNT_W'(1);
               end
            end else begin
               state_s = DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_s = STOP;
            end else begin
               state_s = PARITY;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Line level of the bit currently in progress; registered one edge later
   always_comb begin
      tx_s = LINE_IDLE;
      case (state_r)
         START:   tx_s = START_LEVEL;
         DATA:    tx_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_s = parity_r;
`endif
         default: tx_s = LINE_IDLE;
      endcase
   end

   // Frame state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         shift_r <= {DATA_BITS{1'b0}};
         idx_r   <= {BIT_CNT_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         tx_r    <= LINE_IDLE;
      end else begin
         state_r <= state_s;
         shift_r <= shift_s;
         idx_r   <= idx_s;
         busy_r  <= (state_s != IDLE);
         done_r  <= done_s;
         tx_r    <= tx_s;
      end
   end

   assign tx        = tx_r;
   assign host.busy = busy_r;
   assign host.done = done_r;

endmodule
